// File: rtl/sa_drain_ctrl.sv
// Drain sequencer for systolic-array partial sums through the triangular deskew stage.
// Issues rows under downstream credit control and tags each aligned output row.
module sa_drain_ctrl #(
  parameter int N_SIZE    = 16,
  parameter int ROW_CNT_W = 8,
  parameter int CREDITS   = 4,
  parameter int CRED_W    = $clog2(CREDITS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ROW_CNT_W-1:0] num_rows,
  input  logic                 credit_return,
  output logic                 drain_en,
  output logic                 out_valid,
  output logic [ROW_CNT_W-1:0] out_row_idx,
  output logic                 out_first,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done,
  output logic                 err_credit_ovf
);

  localparam int LAT = N_SIZE - 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [CRED_W-1:0]    CRED_MAX = CRED_W'(CREDITS);
  localparam logic [CRED_W-1:0]    CRED_ONE = CRED_W'(1);
  localparam logic [ROW_CNT_W-1:0] ROW_ONE  = ROW_CNT_W'(1);

  logic [1:0]           state_q, state_d;
  logic [ROW_CNT_W-1:0] rows_q, rows_d;
  logic [ROW_CNT_W-1:0] issued_q, issued_d;
  logic [ROW_CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [CRED_W-1:0]    credits_q, credits_d;
  logic [LAT-1:0]       vld_pipe_q, vld_pipe_d;
  logic                 err_q, err_d;

  logic issue;
  logic last_row;

  assign issue    = (state_q == S_DRAIN) && (credits_q != '0) && (issued_q != rows_q);
  assign last_row = (out_cnt_q == rows_q - ROW_ONE);

  assign drain_en       = issue;
  assign out_valid      = vld_pipe_q[LAT-1];
  assign out_row_idx    = out_valid ? out_cnt_q : '0;
  assign out_first      = out_valid && (out_cnt_q == '0);
  assign out_last       = out_valid && last_row;
  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign err_credit_ovf = err_q;

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    rows_d    = rows_q;
    issued_d  = issued_q;
    out_cnt_d = out_cnt_q;

    if (out_valid) begin
      out_cnt_d = out_cnt_q + ROW_ONE;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_rows == '0) begin
            state_d = S_DONE;
          end else begin
            state_d   = S_DRAIN;
            rows_d    = num_rows;
            issued_d  = '0;
            out_cnt_d = '0;
          end
        end
      end
      S_DRAIN: begin
        if (issue) begin
          issued_d = issued_q + ROW_ONE;
          if (issued_q + ROW_ONE == rows_q) begin
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        // The last aligned row leaving the deskew stage means the pipe is empty next cycle.
        if (out_valid && last_row) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A coincident issue and return cancel out; a lone return at full count is an overflow.
  always_comb begin
    credits_d = credits_q;
    err_d     = err_q;
    if (issue && !credit_return) begin
      credits_d = credits_q - CRED_ONE;
    end else if (!issue && credit_return) begin
      if (credits_q == CRED_MAX) begin
        err_d = 1'b1;
      end else begin
        credits_d = credits_q + CRED_ONE;
      end
    end
  end

  always_comb begin
    vld_pipe_d    = '0;
    vld_pipe_d[0] = issue;
    for (int i = 1; i < LAT; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rows_q     <= '0;
      issued_q   <= '0;
      out_cnt_q  <= '0;
      credits_q  <= CRED_MAX;
      // NOTE: the valid shift register is reset so rows in flight at reset never surface.
      vld_pipe_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rows_q     <= rows_d;
      issued_q   <= issued_d;
      out_cnt_q  <= out_cnt_d;
      credits_q  <= credits_d;
      vld_pipe_q <= vld_pipe_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_sa_drain_ctrl.sv
// Self-checking bench for sa_drain_ctrl: directed scenarios plus randomized drains
// compared against a row-tracking reference model built from queues and counters.
module tb_sa_drain_ctrl;

  localparam int N_SIZE    = 16;
  localparam int ROW_CNT_W = 8;
  localparam int CREDITS   = 4;
  localparam int LAT       = N_SIZE - 1;
  localparam int VW        = 7 + ROW_CNT_W;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic [ROW_CNT_W-1:0] num_rows = '0;
  logic                 credit_return = 1'b0;
  logic                 drain_en, out_valid, out_first, out_last, busy, done, err_credit_ovf;
  logic [ROW_CNT_W-1:0] out_row_idx;

  sa_drain_ctrl #(
    .N_SIZE(N_SIZE), .ROW_CNT_W(ROW_CNT_W), .CREDITS(CREDITS)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_rows(num_rows),
    .credit_return(credit_return), .drain_en(drain_en), .out_valid(out_valid),
    .out_row_idx(out_row_idx), .out_first(out_first), .out_last(out_last),
    .busy(busy), .done(done), .err_credit_ovf(err_credit_ovf)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model: counts of issued/emitted rows, credit balance, arrival times of rows.
  bit m_active;
  int m_rows, m_issued, m_emitted, m_credits, m_done_cyc;
  bit m_err;
  int m_arr[$];

  bit e_de, e_ov, e_first, e_last, e_busy, e_done, e_err;
  int e_idx;
  logic [VW-1:0] exp_vec, obs_vec;
  logic o_de, o_ov, o_first, o_last, o_busy, o_done, o_err;
  logic [ROW_CNT_W-1:0] o_idx;

  function automatic void model_reset();
    m_active = 0; m_rows = 0; m_issued = 0; m_emitted = 0;
    m_credits = CREDITS; m_done_cyc = -1; m_err = 0;
    m_arr.delete();
  endfunction

  function automatic bit peek_valid();
    return (m_arr.size() > 0) && (m_arr[0] == cyc);
  endfunction

  function automatic void model_expect();
    e_de    = m_active && (m_issued < m_rows) && (m_credits > 0);
    e_ov    = peek_valid();
    e_first = e_ov && (m_emitted == 0);
    e_last  = e_ov && (m_emitted == m_rows - 1);
    e_idx   = e_ov ? m_emitted : 0;
    e_busy  = m_active;
    e_done  = m_active && (cyc == m_done_cyc);
    e_err   = m_err;
  endfunction

  function automatic void model_advance(input bit s, input int m, input bit cr);
    if (e_de) begin
      m_issued++;
      m_arr.push_back(cyc + LAT);
    end
    if (e_de && !cr) m_credits--;
    else if (!e_de && cr) begin
      if (m_credits == CREDITS) m_err = 1;
      else m_credits++;
    end
    if (e_ov) begin
      void'(m_arr.pop_front());
      m_emitted++;
      if (e_last) m_done_cyc = cyc + 1;
    end
    if (e_done) m_active = 0;
    else if (!m_active && s) begin
      m_active = 1; m_rows = m; m_issued = 0; m_emitted = 0;
      m_done_cyc = (m == 0) ? cyc + 1 : -1;
    end
  endfunction

  // One clock cycle: drive inputs, sample outputs on the falling edge, advance the model.
  task automatic step(input bit s, input int m, input bit cr);
    start = s; num_rows = ROW_CNT_W'(m); credit_return = cr;
    model_expect();
    exp_vec = {e_de, e_ov, e_first, e_last, e_busy, e_done, e_err, ROW_CNT_W'(e_idx)};
    @(negedge clk);
    o_de = drain_en; o_ov = out_valid; o_first = out_first; o_last = out_last;
    o_busy = busy; o_done = done; o_err = err_credit_ovf; o_idx = out_row_idx;
    obs_vec = {o_de, o_ov, o_first, o_last, o_busy, o_done, o_err, o_idx};
    model_advance(s, m, cr);
    @(posedge clk); #1;
    cyc++;
    start = 1'b0; credit_return = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if ({drain_en, out_valid, out_first, out_last, busy, done, err_credit_ovf, out_row_idx} !== '0) begin
      fails++;
      $display("FAIL reset_outputs got=%b%b%b%b%b%b%b idx=%0d exp=all zero", drain_en, out_valid,
               out_first, out_last, busy, done, err_credit_ovf, out_row_idx);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    cyc = 0;
    for (int c = 0; c < 3; c++) begin
      step(0, 0, 0);
      tests++;
      if (obs_vec !== exp_vec) begin
        fails++; $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc - 1, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_basic();
    logic [6+ROW_CNT_W-1:0] d_exp, d_obs;
    cyc = 0;
    for (int c = 0; c < 22; c++) begin
      step(c == 0, 3, peek_valid());
      tests++;
      if (obs_vec !== exp_vec) begin
        fails++; $display("FAIL basic_model cyc=%0d got=%h exp=%h", c, obs_vec, exp_vec);
      end
      d_exp = {(c >= 1 && c <= 3), (c >= 16 && c <= 18), (c == 16), (c == 18),
               (c >= 1 && c <= 19), (c == 19),
               ROW_CNT_W'((c >= 16 && c <= 18) ? c - 16 : 0)};
      d_obs = {o_de, o_ov, o_first, o_last, o_busy, o_done, o_idx};
      tests++;
      if (d_obs !== d_exp) begin
        fails++; $display("FAIL basic_timing cyc=%0d got=%h exp=%h", c, d_obs, d_exp);
      end
    end
  endtask

  task automatic test_credit_stall();
    int done_cnt = 0;
    bit d_de, d_ov;
    cyc = 0;
    for (int c = 0; c < 35; c++) begin
      step(c == 0, 6, c == 10);
      d_de = (c >= 1 && c <= 4) || (c == 11);
      d_ov = (c >= 16 && c <= 19) || (c == 26);
      tests++;
      if (obs_vec !== exp_vec || o_de !== d_de || o_ov !== d_ov || o_done !== 1'b0) begin
        fails++;
        $display("FAIL stall cyc=%0d got=%h exp=%h de/ov/done=%b%b%b want=%b%b0",
                 c, obs_vec, exp_vec, o_de, o_ov, o_done, d_de, d_ov);
      end
    end
    step(0, 0, 1);
    for (int c = 36; c < 60; c++) begin
      step(0, 0, 0);
      done_cnt += int'(o_done);
      tests++;
      if (obs_vec !== exp_vec) begin
        fails++; $display("FAIL stall_resume cyc=%0d got=%h exp=%h", c, obs_vec, exp_vec);
      end
    end
    tests++;
    if (done_cnt != 1) begin
      fails++; $display("FAIL stall_done_count got=%0d exp=1", done_cnt);
    end
    for (int c = 0; c < 4; c++) step(0, 0, 1);
  endtask

  task automatic test_zero_rows();
    cyc = 0;
    for (int c = 0; c < 5; c++) begin
      step(c == 0, 0, 0);
      tests++;
      if (obs_vec !== exp_vec || o_busy !== (c == 1) || o_done !== (c == 1) || o_de || o_ov) begin
        fails++; $display("FAIL zero_rows cyc=%0d got=%h exp=%h", c, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_credit_edges();
    int de_cnt = 0;
    cyc = 0;
    for (int c = 0; c < 26; c++) begin
      step(c == 0, 5, c == 1);
      tests++;
      if (obs_vec !== exp_vec || o_de !== (c >= 1 && c <= 5) || o_err !== 1'b0) begin
        fails++; $display("FAIL coincident_credit cyc=%0d got=%h exp=%h", c, obs_vec, exp_vec);
      end
    end
    for (int c = 0; c < 4; c++) step(0, 0, 1);
    step(0, 0, 1);
    for (int c = 0; c < 5; c++) begin
      step(0, 0, 0);
      tests++;
      if (o_err !== 1'b1 || obs_vec !== exp_vec) begin
        fails++; $display("FAIL idle_overflow err=%b exp=1 got=%h exp=%h", o_err, obs_vec, exp_vec);
      end
    end
    cyc = 0;
    for (int c = 0; c < 14; c++) begin
      step(c == 0, 6, 0);
      de_cnt += int'(o_de);
    end
    tests++;
    if (de_cnt != CREDITS) begin
      fails++; $display("FAIL credits_after_ovf issued=%0d exp=%0d", de_cnt, CREDITS);
    end
    for (int c = 14; c < 40; c++) begin
      step(0, 0, peek_valid());
      tests++;
      if (obs_vec !== exp_vec) begin
        fails++; $display("FAIL ovf_drain cyc=%0d got=%h exp=%h", c, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_start_ignored();
    int ov_cnt = 0, done_cnt = 0;
    cyc = 0;
    for (int c = 0; c < 26; c++) begin
      step(c == 0 || c == 5, (c == 0) ? 3 : 7, peek_valid());
      ov_cnt += int'(o_ov);
      done_cnt += int'(o_done);
    end
    tests++;
    if (ov_cnt != 3 || done_cnt != 1) begin
      fails++; $display("FAIL start_ignored valid=%0d done=%0d exp=3,1", ov_cnt, done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int ov_cnt = 0;
    cyc = 0;
    for (int c = 0; c < 8; c++) step(c == 0, 10, 0);
    rst = 1'b1;
    #1;
    tests++;
    if ({drain_en, out_valid, out_first, out_last, busy, done, err_credit_ovf, out_row_idx} !== '0) begin
      fails++; $display("FAIL reset_mid_outputs busy=%b de=%b err=%b exp=0", busy, drain_en, err_credit_ovf);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    cyc = 9;
    for (int c = 9; c <= 30; c++) begin
      step(0, 0, 0);
      ov_cnt += int'(o_ov);
      tests++;
      if (obs_vec !== exp_vec) begin
        fails++; $display("FAIL reset_mid_quiet cyc=%0d got=%h exp=%h", c, obs_vec, exp_vec);
      end
    end
    tests++;
    if (ov_cnt != 0) begin
      fails++; $display("FAIL reset_mid_stale_rows got=%0d exp=0", ov_cnt);
    end
    cyc = 0;
    for (int c = 0; c < 24; c++) begin
      step(c == 0, 4, peek_valid());
      tests++;
      if (obs_vec !== exp_vec || (c == 16 && (o_ov !== 1'b1 || o_idx !== '0 || o_first !== 1'b1))) begin
        fails++; $display("FAIL reset_mid_restart cyc=%0d got=%h exp=%h", c, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_random();
    int held = 0;
    int m, budget;
    bit cr, s, first;
    for (int d = 0; d < 10; d++) begin
      m = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 24));
      first = 1;
      budget = 0;
      while (first || m_active) begin
        s = first || (m_active && ($urandom_range(0, 15) == 0));
        cr = (held > 0) && ($urandom_range(0, 2) == 0);
        held -= int'(cr);
        step(s, first ? m : int'($urandom_range(0, 30)), cr);
        held += int'(e_ov);
        first = 0;
        tests++;
        if (obs_vec !== exp_vec) begin
          fails++; $display("FAIL random drain=%0d m=%0d cyc=%0d got=%h exp=%h", d, m, cyc - 1, obs_vec, exp_vec);
        end
        budget++;
        if (budget > 600) begin
          tests++; fails++;
          $display("FAIL random_timeout drain=%0d m=%0d", d, m);
          break;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_credit_stall();
    test_zero_rows();
    test_credit_edges();
    test_start_ignored();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sa_drain_ctrl.md
Name: sa_drain_ctrl

Overview:
- Sequences the drain of systolic-array partial sums through the triangular shift-down deskew stage.
- Issues one row per cycle into the deskew stage and tracks each row through the fixed deskew latency.
- Flags each fully aligned output row with valid, index and first/last markers.
- Gates issue on credits from the downstream row buffer, so the non-stallable deskew pipeline never overruns it.

Parameters:
- N_SIZE, 16, array dimension; deskew latency LAT = N_SIZE-1 cycles.
- ROW_CNT_W, 8, width of row count and row index.
- CREDITS, 4, downstream row-buffer depth (initial credit count), >=1.
- CRED_W, $clog2(CREDITS+1), credit counter width (derived).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  1-cycle request to begin a drain; ignored while busy.
- num_rows  in  ROW_CNT_W  rows to drain (M), sampled when start is accepted.
- credit_return  in  1  1-cycle pulse: downstream freed one row slot.
- drain_en  out  1  array shifts one row into the deskew input this cycle.
- out_valid  out  1  deskew output (psum_out) holds a complete aligned row.
- out_row_idx  out  ROW_CNT_W  index of the row on psum_out; 0..M-1.
- out_first  out  1  qualifies out_valid: row 0.
- out_last  out  1  qualifies out_valid: row M-1.
- busy  out  1  drain in progress.
- done  out  1  1-cycle pulse when the drain completes.
- err_credit_ovf  out  1  sticky: credit_return received while credits == CREDITS.

Behaviour:
- Reset (rst=1, async): FSM=IDLE; credits=CREDITS; issue/output counters=0; valid pipeline cleared.
- Outputs at reset: drain_en, out_valid, out_first, out_last, busy, done, err_credit_ovf all 0; out_row_idx=0.
- A reset mid-drain discards all in-flight rows; no out_valid follows for them.
- FSM states:
  - IDLE: on start with M>0, latch M and go to DRAIN. On start with M=0, go to DONE.
  - DRAIN: drain_en = (credits>0) && (issued<M). Go to FLUSH in the cycle after the last issue.
  - FLUSH: wait until the valid pipeline is empty, i.e. the cycle after out_valid && out_last. Then go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- busy=1 in DRAIN, FLUSH and DONE; busy=0 in IDLE.
- start while busy is ignored; num_rows is not re-sampled.
- Latency:
  - A row issued (drain_en=1) in cycle t gives out_valid=1 in cycle t+LAT.
  - The LAT-deep valid shift register is driven by drain_en.
  - out_row_idx increments on each out_valid and resets to 0 at drain start.
  - out_first/out_last are 0 whenever out_valid=0.
- Credits:
  - Each issue decrements the counter; each credit_return increments it.
  - Issue and credit_return in the same cycle leave it unchanged.
  - A credit_return at CREDITS is dropped, sets err_credit_ovf and leaves the counter at CREDITS.
  - err_credit_ovf clears only on rst.
  - credit_return is accepted in every state, including IDLE.
  - A credit returned in cycle c can enable an issue no earlier than cycle c+1 (registered counter).
- drain_en never asserts when credits=0 or when issued==M; gaps in issue are allowed.
- out_valid need not be contiguous; valid/index tracking follows the gaps exactly.
- Counters never wrap: M <= 2^ROW_CNT_W-1.
- All outputs are registered or decoded directly from FSM state; there is no combinational path from inputs to outputs.

Test Plan:
- Basic drain (N_SIZE=16, CREDITS=4): start with M=3 in cycle 0, credit_return pulsed with each out_valid -> drain_en in cycles 1-3; out_valid in cycles 16,17,18 with idx 0,1,2; out_first in cycle 16, out_last in cycle 18; done in cycle 19; busy in cycles 1-19.
- Credit stall: M=6, no returns -> drain_en in cycles 1-4 then 0. Single credit_return in cycle 10 -> drain_en in cycle 11; out_valid in cycles 16-19 and 26; issue then stalls at 5 of 6, no done until another credit is returned.
- Zero rows: start with M=0 -> done in cycle 1, busy in cycle 1 only, no drain_en, no out_valid.
- Credit edge cases: credit_return coincident with drain_en -> counter unchanged. credit_return in IDLE with credits=4 -> err_credit_ovf=1 and stays 1, credits stay 4.
- Reset mid-drain: M=10, rst asserted in cycle 8 -> all outputs 0 immediately, credits=4, no out_valid in cycles 9-30. A new start then drains normally from idx 0.
- start ignored when busy: second start with M=7 in cycle 5 of an M=3 drain -> exactly 3 out_valid and one done pulse.
